// File: rtl/inert_pkg.sv
// Shared types, defaults and helpers for the inertial pitch integrator.
package inert_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAL,
        RUN
    } state_e;

    localparam int unsigned     INT_W           = 27;
    localparam logic [9:0]      ACC_GAIN_DEF    = 10'd327;
    localparam logic [INT_W-1:0] FUSION_STEP_DEF = 27'd1024;

    // Saturate a 19-bit signed value into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v[18:15] == {4{v[18]}}) begin
            return v[15:0];
        end
        return v[18] ? 16'sh8000 : 16'sh7FFF;
    endfunction

endpackage

// File: rtl/inertial_integrator_if.sv
// Sample/result bus between the inertial front-end and the pitch integrator.
interface inertial_integrator_if;
    logic               vld_in;
    logic signed [15:0] ptch_rt_raw;
    logic signed [15:0] AZ_raw;
    logic               cal_req;
    logic               clr_int;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic               vld;
    logic               cal_done;

    // Sample producer / result consumer side.
    modport master (
        output vld_in, ptch_rt_raw, AZ_raw, cal_req, clr_int,
        input  ptch, ptch_rt, vld, cal_done
    );

    // Integrator side.
    modport slave (
        input  vld_in, ptch_rt_raw, AZ_raw, cal_req, clr_int,
        output ptch, ptch_rt, vld, cal_done
    );
endinterface

// File: rtl/inert_cal_avg.sv
// Offset calibration: averages 2^CAL_LOG2 raw gyro/accel samples.
module inert_cal_avg
    import inert_pkg::*;
#(
    parameter int unsigned CAL_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               en_i,
    input  logic               vld_i,
    input  logic signed [15:0] gyro_i,
    input  logic signed [15:0] az_i,
    output logic signed [15:0] gyro_off_o,
    output logic signed [15:0] az_off_o,
    output logic               last_o,
    output logic               done_o
);

    localparam int unsigned ACC_W = 16 + CAL_LOG2;

    logic signed [ACC_W-1:0] gacc_q, gacc_d;
    logic signed [ACC_W-1:0] aacc_q, aacc_d;
    logic [CAL_LOG2-1:0]     cnt_q;
    logic signed [15:0]      gyro_off_q, az_off_q;
    logic                    done_q;

    // Running sums including the current sample; final sample is recognised here.
    always_comb begin
        gacc_d = gacc_q + ACC_W'(gyro_i);
        aacc_d = aacc_q + ACC_W'(az_i);
        last_o = en_i && vld_i && (cnt_q == '1);
    end

    // Accumulate in CAL; on the last sample the top 16 bits of the sum are the
    // arithmetic shift right by CAL_LOG2, i.e. the average.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gacc_q     <= '0;
            aacc_q     <= '0;
            cnt_q      <= '0;
            gyro_off_q <= '0;
            az_off_q   <= '0;
            done_q     <= 1'b0;
        end else if (start_i) begin
            gacc_q <= '0;
            aacc_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en_i && vld_i) begin
                if (last_o) begin
                    gyro_off_q <= gacc_d[ACC_W-1 -: 16];
                    az_off_q   <= aacc_d[ACC_W-1 -: 16];
                    gacc_q     <= '0;
                    aacc_q     <= '0;
                    cnt_q      <= '0;
                    done_q     <= 1'b1;
                end else begin
                    gacc_q <= gacc_d;
                    aacc_q <= aacc_d;
                    cnt_q  <= cnt_q + CAL_LOG2'(1);
                end
            end
        end
    end

    assign gyro_off_o = gyro_off_q;
    assign az_off_o   = az_off_q;
    assign done_o     = done_q;

endmodule

// File: rtl/inertial_integrator.sv
// Pitch integrator: offset compensation, gyro integration, complementary fusion.
module inertial_integrator
    import inert_pkg::*;
#(
    parameter int unsigned      CAL_LOG2    = 8,
    parameter logic [9:0]       ACC_GAIN    = ACC_GAIN_DEF,
    parameter logic [INT_W-1:0] FUSION_STEP = FUSION_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inertial_integrator_if.slave  bus
);

    state_e                    state_q;
    logic                      vld_q;
    logic signed [15:0]        ptch_rt_q;
    logic signed [INT_W-1:0]   ptch_int_q, ptch_int_d;

    logic                      cal_start, in_cal, cal_last, cal_done;
    logic signed [15:0]        gyro_off, az_off;

    logic signed [16:0]        rt_diff, az_diff;
    logic signed [15:0]        rt_comp, az_comp, ptch_cur;
    logic signed [INT_W-1:0]   prod, ptch_acc;
    logic signed [INT_W:0]     fus, sum;

    assign in_cal    = (state_q == CAL);
    assign cal_start = bus.cal_req && !in_cal;

    inert_cal_avg #(
        .CAL_LOG2 (CAL_LOG2)
    ) u_cal (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (cal_start),
        .en_i       (in_cal),
        .vld_i      (bus.vld_in),
        .gyro_i     (bus.ptch_rt_raw),
        .az_i       (bus.AZ_raw),
        .gyro_off_o (gyro_off),
        .az_off_o   (az_off),
        .last_o     (cal_last),
        .done_o     (cal_done)
    );

    // Compensation, accel pitch estimate, fusion correction and clamped integration.
    always_comb begin
        rt_diff  = {bus.ptch_rt_raw[15], bus.ptch_rt_raw} - {gyro_off[15], gyro_off};
        az_diff  = {bus.AZ_raw[15], bus.AZ_raw} - {az_off[15], az_off};
        rt_comp  = sat16({{2{rt_diff[16]}}, rt_diff});
        az_comp  = sat16({{2{az_diff[16]}}, az_diff});
        prod     = $signed({{11{az_comp[15]}}, az_comp}) * $signed({17'd0, ACC_GAIN});
        // prod >>> 13 always fits 14 bits, so this equals sext(prod[26:13]).
        ptch_acc = prod >>> 13;
        ptch_cur = sat16(ptch_int_q[INT_W-1:8]);
        if (ptch_acc > INT_W'(ptch_cur)) begin
            fus = {1'b0, FUSION_STEP};
        end else begin
            fus = -{1'b0, FUSION_STEP};
        end
        sum = {ptch_int_q[INT_W-1], ptch_int_q} - {{12{rt_comp[15]}}, rt_comp} + fus;
        if (sum[INT_W] != sum[INT_W-1]) begin
            ptch_int_d = sum[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        end else begin
            ptch_int_d = sum[INT_W-1:0];
        end
    end

    // Mode FSM with registered rate, integrator and result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vld_q      <= 1'b0;
            ptch_rt_q  <= '0;
            ptch_int_q <= '0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cal_req) begin
                        state_q    <= CAL;
                        ptch_rt_q  <= '0;
                        ptch_int_q <= '0;
                    end
                end
                CAL: begin
                    if (cal_last) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.cal_req) begin
                        state_q    <= CAL;
                        ptch_rt_q  <= '0;
                        ptch_int_q <= '0;
                    end else if (bus.vld_in) begin
                        vld_q      <= 1'b1;
                        ptch_rt_q  <= rt_comp;
                        ptch_int_q <= ptch_int_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Rider-off clear overrides any integrator update in the same cycle.
            if (bus.clr_int) begin
                ptch_int_q <= '0;
            end
        end
    end

    assign bus.ptch     = ptch_cur;
    assign bus.ptch_rt  = ptch_rt_q;
    assign bus.vld      = vld_q;
    assign bus.cal_done = cal_done;

endmodule

// File: tb/tb_inertial_integrator.sv
// Scoreboard bench for inertial_integrator with an arithmetic reference model.
module tb_inertial_integrator;

    localparam int GAIN = 327;
    localparam int STEP = 1024;
    localparam int NCAL = 16;

    typedef struct {
        bit is_cal;
        int ptch;
        int rt;
    } exp_t;

    logic clk;
    logic rst_n;
    inertial_integrator_if bus();

    inertial_integrator #(
        .CAL_LOG2 (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t   q[$];
    int     vectors;
    int     miscompares;

    // reference model state
    int     mode;      // 0 idle, 1 calibrating, 2 running
    int     mcnt;
    int     sg, sa;
    int     goff, aoff;
    longint pint;

    function automatic int sat16(longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int ptch_of(longint p);
        return sat16(p >>> 8);
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = 0; mcnt = 0; sg = 0; sa = 0; goff = 0; aoff = 0; pint = 0;
    endtask

    // One clock of stimulus; the model predicts what the coming edge produces.
    task automatic step(bit vin, int gr, int az, bit calr, bit clr);
        int     rt, azc, pacc, fus;
        longint n;
        exp_t   e;
        bus.vld_in      = vin;
        bus.ptch_rt_raw = 16'(gr);
        bus.AZ_raw      = 16'(az);
        bus.cal_req     = calr;
        bus.clr_int     = clr;
        case (mode)
            0: begin
                if (calr) begin
                    mode = 1; mcnt = 0; sg = 0; sa = 0; pint = 0;
                end
            end
            1: begin
                if (vin) begin
                    sg += gr; sa += az; mcnt++;
                    if (mcnt == NCAL) begin
                        goff = sg >>> 4;
                        aoff = sa >>> 4;
                        mode = 2;
                        e.is_cal = 1'b1; e.ptch = 0; e.rt = 0;
                        q.push_back(e);
                    end
                end
            end
            default: begin
                if (calr) begin
                    mode = 1; mcnt = 0; sg = 0; sa = 0; pint = 0;
                end else if (vin) begin
                    rt   = sat16(gr - goff);
                    azc  = sat16(az - aoff);
                    pacc = (azc * GAIN) >>> 13;
                    fus  = (pacc > ptch_of(pint)) ? STEP : -STEP;
                    n    = pint - rt + fus;
                    if (n > (longint'(1) <<< 26) - 1) n = (longint'(1) <<< 26) - 1;
                    if (n < -(longint'(1) <<< 26))    n = -(longint'(1) <<< 26);
                    pint = clr ? 0 : n;
                    e.is_cal = 1'b0; e.ptch = ptch_of(pint); e.rt = rt;
                    q.push_back(e);
                end
            end
        endcase
        if (clr) pint = 0;
        @(posedge clk);
        #1;
        bus.vld_in  = 1'b0;
        bus.cal_req = 1'b0;
        bus.clr_int = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        model_reset();
        @(negedge clk);
        check("rst_ptch", int'(bus.ptch), 0);
        check("rst_ptch_rt", int'(bus.ptch_rt), 0);
        check("rst_vld", int'(bus.vld), 0);
        check("rst_cal_done", int'(bus.cal_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Monitor: every reported result is matched against the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.vld || bus.cal_done)) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: vld=%0d cal_done=%0d with nothing expected at %0t",
                             bus.vld, bus.cal_done, $time);
                end else begin
                    e = q.pop_front();
                    check("kind_cal_done", int'(bus.cal_done), int'(e.is_cal));
                    if (!e.is_cal) begin
                        check("ptch", int'(bus.ptch), e.ptch);
                        check("ptch_rt", int'(bus.ptch_rt), e.rt);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        rst_n           = 1'b0;
        bus.vld_in      = 1'b0;
        bus.ptch_rt_raw = '0;
        bus.AZ_raw      = '0;
        bus.cal_req     = 1'b0;
        bus.clr_int     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // strobes while idle must produce nothing
        for (int i = 0; i < 5; i++) step(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);

        // calibration on constant samples, with gaps and an ignored cal_req
        step(1'b0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < NCAL; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            step(1'b1, 100, -40, (i == 5), 1'b0);
        end
        idle(2);

        // zero motion: ptch alternates -4 / 0, back-to-back samples
        for (int i = 0; i < 6; i++) step(1'b1, 100, -40, 1'b0, 1'b0);
        idle(1);

        // gyro integration from a cleared integrator
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 612, -40, 1'b0, 1'b0);
        idle(1);

        // positive saturation of the pitch output
        for (int i = 0; i < 300; i++) step(1'b1, -32768, -40, 1'b0, 1'b0);
        idle(1);
        check("sat_ptch_max", int'(bus.ptch), 32767);

        // clear coincident with a sample
        step(1'b1, rnd16(), rnd16(), 1'b0, 1'b1);
        idle(1);

        // recalibration request from RUN with a coincident sample
        step(1'b1, 100, -40, 1'b1, 1'b0);
        idle(1);
        check("recal_ptch_zero", int'(bus.ptch), 0);
        check("recal_ptch_rt_zero", int'(bus.ptch_rt), 0);

        // calibration with random offsets
        for (int i = 0; i < NCAL; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            step(1'b1, int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 4000)) - 2000, 1'b0, 1'b0);
        end
        idle(2);

        // random traffic including clears and occasional recalibration
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rnd16(), rnd16(),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0));
        end
        idle(2);

        // reset in the middle of activity, then idle strobes
        step(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);
        idle(3);

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
